uart_ram_master: RTL and testbench

UART_RAM_MASTER -- requirements
Module: uart_ram_master

---
 rtl/uart_ram_master.sv | 186 ++++++++++++++++++
 tb/tb_uart_ram_master.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ram_master.sv
// uart_ram_master: turns host read/write requests into byte frames for a
// UART transmitter (write = CMD_WR, addr, wdata; read = CMD_RD, addr) and
// collects the single response byte of a read from the UART receiver.
//
// Build option: define UART_RAM_MASTER_TIMEOUT_EN to give up on a read whose
// response has not arrived within TIMEOUT_CYCLES cycles. The default build
// waits for the response indefinitely and ties rsp_timeout to 0.
//
// Handshake: a host request transfers on a rising edge where cmd_valid and
// cmd_ready are both 1; cmd_ready is 1 only in IDLE, and cmd_wr/cmd_addr/
// cmd_wdata are captured on that edge. The request source may hold cmd_valid
// high; nothing else is accepted until the FSM has returned to IDLE.
//
// Every wait state first records its event (tx_done, rx_valid or timeout) in
// ev_q and acts on it one cycle later. That extra cycle is the slot where
// done and rsp_data are visible together while the FSM is still busy, so a
// new request can only be accepted in the cycle after done.
module uart_ram_master #(
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0] CMD_WR         = 8'hF0,
    parameter logic [7:0] CMD_RD         = 8'h0F
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_wr,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       tx_start,
    output logic [7:0] tx_byte,
    input  logic       tx_done,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic       done,
    output logic [7:0] rsp_data,
    output logic       rsp_timeout,
    output logic       busy,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND_CMD  = 3'd1,
        WAIT_CMD  = 3'd2,
        SEND_ADDR = 3'd3,
        WAIT_ADDR = 3'd4,
        SEND_DATA = 3'd5,
        WAIT_DATA = 3'd6,
        WAIT_RSP  = 3'd7
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic       req_wr_q;
    logic [7:0] req_addr_q;
    logic [7:0] req_wdata_q;
    logic [7:0] tx_byte_q;
    logic [7:0] rsp_data_q;
    logic       ev_q;
    logic       accept;
    logic       in_tx_wait;
    logic       rx_take;
    logic       timeout_hit;
    logic       ev_set;
    logic       load_en;
    logic [7:0] load_byte;

    assign cmd_ready  = (state_q == IDLE) && !rst;
    assign accept     = cmd_valid && cmd_ready;
    assign in_tx_wait = (state_q == WAIT_CMD) || (state_q == WAIT_ADDR) ||
                        (state_q == WAIT_DATA);
    // Only the first response byte of a read counts; later ones are dropped.
    assign rx_take    = (state_q == WAIT_RSP) && !ev_q && rx_valid;
    assign ev_set     = (in_tx_wait && !ev_q && tx_done) || rx_take || timeout_hit;

`ifdef UART_RAM_MASTER_TIMEOUT_EN
    logic [19:0] to_cnt_q;
    logic        to_q;

    // A response arriving in the expiry cycle wins over the timeout.
    assign timeout_hit = (state_q == WAIT_RSP) && !ev_q && !rx_valid &&
                         (to_cnt_q == 20'(TIMEOUT_CYCLES - 1));

    // Response-wait counter: cleared on the way into WAIT_RSP, frozen once an event is pending.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            to_cnt_q <= 20'd0;
            to_q     <= 1'b0;
        end else begin
            to_q <= timeout_hit;
            if (state_q == WAIT_ADDR && ev_q) begin
                to_cnt_q <= 20'd0;
            end else if (state_q == WAIT_RSP && !ev_q) begin
                to_cnt_q <= to_cnt_q + 20'd1;
            end
        end
    end

    assign rsp_timeout = done && to_q;
`else
    assign timeout_hit = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    // Next state plus the byte to load on entry to each SEND state.
    always_comb begin
        state_d   = state_q;
        load_en   = 1'b0;
        load_byte = 8'h00;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = SEND_CMD;
                    load_en   = 1'b1;
                    load_byte = cmd_wr ? CMD_WR : CMD_RD;
                end
            end
            SEND_CMD:  state_d = WAIT_CMD;
            WAIT_CMD: begin
                if (ev_q) begin
                    state_d   = SEND_ADDR;
                    load_en   = 1'b1;
                    load_byte = req_addr_q;
                end
            end
            SEND_ADDR: state_d = WAIT_ADDR;
            WAIT_ADDR: begin
                if (ev_q) begin
                    if (req_wr_q) begin
                        state_d   = SEND_DATA;
                        load_en   = 1'b1;
                        load_byte = req_wdata_q;
                    end else begin
                        state_d = WAIT_RSP;
                    end
                end
            end
            SEND_DATA: state_d = WAIT_DATA;
            WAIT_DATA: if (ev_q) state_d = IDLE;
            WAIT_RSP:  if (ev_q) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // State register, request capture, tx byte hold and event flag.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            req_wr_q    <= 1'b0;
            req_addr_q  <= 8'h00;
            req_wdata_q <= 8'h00;
            tx_byte_q   <= 8'h00;
            ev_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            ev_q    <= ev_set;
            if (accept) begin
                req_wr_q    <= cmd_wr;
                req_addr_q  <= cmd_addr;
                req_wdata_q <= cmd_wdata;
            end
            if (load_en) begin
                tx_byte_q <= load_byte;
            end
        end
    end

    // Read result register; holds between reads and through timeouts.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            rsp_data_q <= 8'h00;
        end else if (rx_take) begin
            rsp_data_q <= rx_byte;
        end
    end

    assign tx_start  = (state_q == SEND_CMD) || (state_q == SEND_ADDR) ||
                       (state_q == SEND_DATA);
    assign tx_byte   = tx_byte_q;
    assign done      = ev_q && ((state_q == WAIT_DATA) || (state_q == WAIT_RSP));
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_ram_master.sv
// Directed bench for uart_ram_master. Inputs change and outputs are sampled
// on the falling edge; the DUT acts on the rising edge.
module tb_uart_ram_master;

    logic       sys_clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_wr;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic       tx_done;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       done;
    logic [7:0] rsp_data;
    logic       rsp_timeout;
    logic       busy;
    logic [2:0] state_dbg;

    int checks = 0;
    int errors = 0;
    int tx_count = 0;
    int done_count = 0;
    int snap_tx;
    int snap_done;

    uart_ram_master #(
        .TIMEOUT_CYCLES(100),
        .CMD_WR(8'hF0),
        .CMD_RD(8'h0F)
    ) dut (
        .sys_clk(sys_clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .tx_start(tx_start),
        .tx_byte(tx_byte),
        .tx_done(tx_done),
        .rx_valid(rx_valid),
        .rx_byte(rx_byte),
        .done(done),
        .rsp_data(rsp_data),
        .rsp_timeout(rsp_timeout),
        .busy(busy),
        .state_dbg(state_dbg)
    );

    // Clock
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Pulse counters sampled on the active edge
    always @(posedge sys_clk) begin
        if (tx_start === 1'b1) tx_count++;
        if (done === 1'b1) done_count++;
    end

    task automatic tick();
        @(negedge sys_clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a request for one cycle; the first tx_start follows one cycle later.
    task automatic issue(input string tag, input logic wr, input logic [7:0] addr,
                         input logic [7:0] wdata, input logic [7:0] exp_cmd);
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        tick();
        cmd_valid = 1'b0;
        chk(tag, {23'd0, tx_start, tx_byte}, {23'd0, 1'b1, exp_cmd});
    endtask

    // Called in a SEND cycle: acknowledge the byte, expect the next byte two cycles after tx_done.
    task automatic tx_ack_next(input string tag, input logic [7:0] exp);
        tick();
        chk({tag, "_pulse1"}, tx_start, 1'b0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk({tag, "_gap"}, tx_start, 1'b0);
        tick();
        chk(tag, {23'd0, tx_start, tx_byte}, {23'd0, 1'b1, exp});
    endtask

    // Called in the SEND_DATA cycle: acknowledge the data byte, expect done next cycle.
    task automatic end_write(input string tag, input logic [7:0] exp_rsp);
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk({tag, "_done"}, {done, cmd_ready, rsp_timeout}, 3'b100);
        chk({tag, "_rsp"}, rsp_data, exp_rsp);
        tick();
        chk({tag, "_idle"}, {done, cmd_ready, busy}, 3'b010);
    endtask

    // Called in the SEND_ADDR cycle of a read: ends in the first WAIT_RSP cycle.
    task automatic finish_addr(input string tag);
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk({tag, "_no_done"}, done, 1'b0);
        tick();
        chk({tag, "_wait_rsp"}, {busy, done, tx_start}, 3'b100);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_wr    = 1'b0;
        cmd_addr  = 8'h00;
        cmd_wdata = 8'h00;
        tx_done   = 1'b0;
        rx_valid  = 1'b0;
        rx_byte   = 8'h00;

        // Reset values
        tick();
        chk("rst_ready", cmd_ready, 1'b0);
        chk("rst_outs", {tx_start, done, rsp_timeout, busy}, 4'b0000);
        chk("rst_bytes", {tx_byte, rsp_data}, 16'h0000);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", cmd_ready, 1'b1);

        // Stray tx_done / rx_valid while idle have no effect
        tx_done  = 1'b1;
        rx_valid = 1'b1;
        rx_byte  = 8'h99;
        tick();
        tx_done  = 1'b0;
        rx_valid = 1'b0;
        tick();
        chk("stray_idle", {busy, done, tx_start, rsp_data}, {3'b000, 8'h00});

        // Write 12 <- A5
        snap_tx   = tx_count;
        snap_done = done_count;
        issue("w1_cmd", 1'b1, 8'h12, 8'hA5, 8'hF0);
        tx_ack_next("w1_addr", 8'h12);
        tx_ack_next("w1_data", 8'hA5);
        end_write("w1", 8'h00);
        chk("w1_tx_count", tx_count - snap_tx, 3);
        chk("w1_done_count", done_count - snap_done, 1);

        // Read 12 -> A5
        snap_tx = tx_count;
        issue("r1_cmd", 1'b0, 8'h12, 8'hEE, 8'h0F);
        tx_ack_next("r1_addr", 8'h12);
        finish_addr("r1");
        rx_valid = 1'b1;
        rx_byte  = 8'hA5;
        tick();
        rx_valid = 1'b0;
        chk("r1_done", {done, rsp_timeout, busy}, 3'b101);
        chk("r1_rsp", rsp_data, 8'hA5);
        tick();
        chk("r1_idle", {done, busy, cmd_ready}, 3'b001);
        chk("r1_tx_count", tx_count - snap_tx, 2);

        // rx_valid in WAIT_ADDR ignored, real reply 3C taken
        issue("r2_cmd", 1'b0, 8'h34, 8'h00, 8'h0F);
        tx_ack_next("r2_addr", 8'h34);
        tick();
        rx_valid = 1'b1;
        rx_byte  = 8'h55;
        tick();
        rx_valid = 1'b0;
        chk("r2_stray_rx", {done, rsp_data}, {1'b0, 8'hA5});
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tick();
        chk("r2_wait_rsp", {busy, state_dbg}, {1'b1, 3'd7});
        rx_valid = 1'b1;
        rx_byte  = 8'h3C;
        tick();
        rx_valid = 1'b0;
        chk("r2_done", {done, rsp_data}, {1'b1, 8'h3C});
        tick();
        chk("r2_idle", {done, busy}, 2'b00);

`ifdef UART_RAM_MASTER_TIMEOUT_EN
        // No reply: timeout exactly 100 cycles after entering WAIT_RSP
        issue("t1_cmd", 1'b0, 8'h56, 8'h00, 8'h0F);
        tx_ack_next("t1_addr", 8'h56);
        finish_addr("t1");
        repeat (99) tick();
        chk("t1_not_yet", {done, rsp_timeout}, 2'b00);
        tick();
        chk("t1_timeout", {done, rsp_timeout}, 2'b11);
        chk("t1_rsp_kept", rsp_data, 8'h3C);
        tick();
        chk("t1_idle", {done, rsp_timeout, busy}, 3'b000);

        // Reply in the expiry cycle beats the timeout
        issue("t2_cmd", 1'b0, 8'h57, 8'h00, 8'h0F);
        tx_ack_next("t2_addr", 8'h57);
        finish_addr("t2");
        repeat (99) tick();
        rx_valid = 1'b1;
        rx_byte  = 8'h6B;
        tick();
        rx_valid = 1'b0;
        chk("t2_rx_wins", {done, rsp_timeout, rsp_data}, {2'b10, 8'h6B});
        tick();
        chk("t2_idle", busy, 1'b0);
`else
        // No timeout: still waiting long after, then a late reply completes
        issue("t1_cmd", 1'b0, 8'h56, 8'h00, 8'h0F);
        tx_ack_next("t1_addr", 8'h56);
        finish_addr("t1");
        repeat (150) tick();
        chk("t1_still_wait", {busy, done, rsp_timeout}, 3'b100);
        rx_valid = 1'b1;
        rx_byte  = 8'h77;
        tick();
        rx_valid = 1'b0;
        chk("t1_late_rsp", {done, rsp_timeout, rsp_data}, {2'b10, 8'h77});
        tick();
        chk("t1_idle", busy, 1'b0);
`endif

        // Reset after the second tx_start of a write
        issue("x1_cmd", 1'b1, 8'h9A, 8'hBC, 8'hF0);
        tx_ack_next("x1_addr", 8'h9A);
        rst = 1'b1;
        #1;
        chk("x1_rst_outs", {tx_start, done, rsp_timeout, busy, cmd_ready}, 5'b00000);
        chk("x1_rst_bytes", {tx_byte, rsp_data, 5'd0, state_dbg}, 24'h000000);
        tick();
        rst = 1'b0;
        tick();
        chk("x1_ready", {cmd_ready, busy}, 2'b10);
        issue("x2_cmd", 1'b1, 8'h11, 8'h22, 8'hF0);
        tx_ack_next("x2_addr", 8'h11);
        tx_ack_next("x2_data", 8'h22);
        end_write("x2", 8'h00);

        // cmd_valid held through a write: next accept only after done
        cmd_valid = 1'b1;
        cmd_wr    = 1'b1;
        cmd_addr  = 8'h40;
        cmd_wdata = 8'h41;
        tick();
        chk("h1_cmd", {23'd0, tx_start, tx_byte}, {23'd0, 1'b1, 8'hF0});
        tx_ack_next("h1_addr", 8'h40);
        tx_ack_next("h1_data", 8'h41);
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("h1_done_not_ready", {done, cmd_ready}, 2'b10);
        cmd_addr  = 8'h50;
        cmd_wdata = 8'h51;
        tick();
        chk("h1_idle_ready", {done, cmd_ready, busy}, 3'b010);
        tick();
        cmd_valid = 1'b0;
        chk("h2_cmd", {23'd0, tx_start, tx_byte}, {23'd0, 1'b1, 8'hF0});
        tx_ack_next("h2_addr", 8'h50);
        tx_ack_next("h2_data", 8'h51);
        end_write("h2", 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
